// File: rtl/diff_serial_tx_if.sv
// Word handshake into the serial transmitter: the producer drives s_data/s_valid,
// the transmitter returns a registered s_ready.
interface diff_serial_tx_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/diff_serial_tx.sv
// UART-style frame serialiser (start, LSB-first data, optional even parity under DIFF_TX_PARITY_EN, stop).
// First start-bit cycle follows the accepting edge; s_ready is high only in IDLE, so one IDLE cycle separates frames.
module diff_serial_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [DIV_WIDTH-1:0] div,
  diff_serial_tx_if.slave      s,
  output logic                 dout,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef DIFF_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  dout_q, dout_d;
  logic                  rdy_q, rdy_d;
  logic                  done_q, done_d;
  logic                  tick;
`ifdef DIFF_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  assign tick       = (cnt_q == div_q);
  assign dout       = dout_q;
  assign s.s_ready  = rdy_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      dout_q  <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIFF_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
`ifdef DIFF_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // dout is computed from the state being entered so the line changes on the transition edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
`ifdef DIFF_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        rdy_d  = 1'b1;
        dout_d = 1'b1;
        if (s.s_valid && rdy_q) begin
          state_d = START;
          sh_d    = s.s_data;
          div_d   = div;
          cnt_d   = '0;
          idx_d   = '0;
          rdy_d   = 1'b0;
          dout_d  = 1'b0;
`ifdef DIFF_TX_PARITY_EN
          par_d   = ^s.s_data;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          dout_d  = sh_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef DIFF_TX_PARITY_EN
            state_d = PARITY;
            dout_d  = par_q;
`else
            state_d = STOP;
            dout_d  = 1'b1;
`endif
          end else begin
            sh_d   = sh_q >> 1;
            idx_d  = idx_q + IDX_W'(1);
            dout_d = sh_q[1];
          end
        end
      end
`ifdef DIFF_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          dout_d  = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          dout_d  = 1'b1;
          rdy_d   = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_diff_serial_tx.sv
// Directed bench for diff_serial_tx with DATA_WIDTH=8; expectations follow the frame timing formulas.
module tb_diff_serial_tx;
  localparam int DW = 8;
  localparam int VW = 16;
`ifdef DIFF_TX_PARITY_EN
  localparam int NB = DW + 3;
`else
  localparam int NB = DW + 2;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [VW-1:0] div = '0;
  logic          dout, busy, frame_done;
  int            checks = 0;
  int            passed = 0;

  diff_serial_tx_if #(.DATA_WIDTH(DW)) sif ();

  diff_serial_tx #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div        (div),
    .s          (sif),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Expected line level in cycle k (k=1 is the first cycle after the accepting edge).
  function automatic logic exp_bit(input logic [DW-1:0] d, input int k, input int p);
    int b;
    b = (k - 1) / p;
    if (b == 0) return 1'b0;
    if (b <= DW) return d[b-1];
`ifdef DIFF_TX_PARITY_EN
    if (b == DW + 1) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (sif.s_ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    checks++;
    if (sif.s_ready !== 1'b1) $display("FAIL wait_ready: s_ready=%b after %0d cycles, required 1", sif.s_ready, n);
    else passed++;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    step();
    step();
    checks++;
    if ({dout, busy, frame_done, sif.s_ready} !== 4'b1000)
      $display("FAIL reset_state: dout/busy/done/rdy=%b required 1000", {dout, busy, frame_done, sif.s_ready});
    else passed++;
    resetn = 1'b1;
    #1;
    checks++;
    if (sif.s_ready !== 1'b0) $display("FAIL reset_release_rdy: s_ready=%b required 0", sif.s_ready);
    else passed++;
    step();
    checks++;
    if (sif.s_ready !== 1'b1) $display("FAIL first_edge_rdy: s_ready=%b required 1", sif.s_ready);
    else passed++;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    sif.s_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ({dout, busy, frame_done} !== 3'b100) bad++;
      step();
    end
    checks++;
    if (bad != 0) $display("FAIL idle_line: %0d bad cycles, required 0", bad);
    else passed++;
  endtask

  // Sends one word; div is forced to 0 at cycle chg_k (0 = never) to show it is not re-sampled.
  task automatic test_frame(input logic [DW-1:0] d, input logic [VW-1:0] dv, input int chg_k);
    int p, bad_dout, bad_ctl;
    p = int'(dv) + 1;
    bad_dout = 0;
    bad_ctl = 0;
    wait_ready();
    sif.s_data = d;
    sif.s_valid = 1'b1;
    div = dv;
    step();
    sif.s_valid = 1'b0;
    sif.s_data = ~d;
    for (int k = 1; k <= NB * p; k++) begin
      if (k == chg_k) div = '0;
      if (dout !== exp_bit(d, k, p)) begin
        if (bad_dout == 0) $display("FAIL frame_dout %h k=%0d: dout=%b required %b", d, k, dout, exp_bit(d, k, p));
        bad_dout++;
      end
      if ({busy, frame_done, sif.s_ready} !== 3'b100) bad_ctl++;
      step();
    end
    checks++;
    if (bad_dout != 0) $display("FAIL frame_bits %h: %0d wrong cycles, required 0", d, bad_dout);
    else passed++;
    checks++;
    if (bad_ctl != 0) $display("FAIL frame_ctl %h: %0d wrong busy/done/rdy cycles, required 0", d, bad_ctl);
    else passed++;
    checks++;
    if ({dout, busy, frame_done, sif.s_ready} !== 4'b1011)
      $display("FAIL frame_end %h: dout/busy/done/rdy=%b required 1011", d, {dout, busy, frame_done, sif.s_ready});
    else passed++;
    step();
    checks++;
    if (frame_done !== 1'b0) $display("FAIL done_pulse %h: frame_done=%b required 0", d, frame_done);
    else passed++;
    div = '0;
  endtask

  task automatic test_back_to_back();
    int bad, start2;
    logic [DW-1:0] d;
    bad = 0;
    start2 = -1;
    div = '0;
    wait_ready();
    sif.s_data = 8'h00;
    sif.s_valid = 1'b1;
    step();
    sif.s_data = 8'hFF;
    for (int k = 1; k <= 2 * (NB + 1); k++) begin
      d = (k <= NB + 1) ? 8'h00 : 8'hFF;
      if (k == NB + 1) begin
        checks++;
        if ({dout, frame_done, sif.s_ready} !== 3'b111)
          $display("FAIL b2b_gap: dout/done/rdy=%b required 111", {dout, frame_done, sif.s_ready});
        else passed++;
      end else if (k <= NB) begin
        if (dout !== exp_bit(d, k, 1)) bad++;
      end else begin
        if (k == NB + 2) begin
          sif.s_valid = 1'b0;
          if (dout === 1'b0) start2 = k - 1;
        end
        if (dout !== exp_bit(d, k - NB - 1, 1)) bad++;
      end
      step();
    end
    checks++;
    if (start2 != NB + 1) $display("FAIL b2b_start_spacing: second start after %0d cycles, required %0d", start2, NB + 1);
    else passed++;
    checks++;
    if (bad != 0) $display("FAIL b2b_bits: %0d wrong cycles, required 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    pulses = 0;
    div = 16'd3;
    wait_ready();
    sif.s_data = 8'hC3;
    sif.s_valid = 1'b1;
    step();
    sif.s_valid = 1'b0;
    for (int k = 1; k < 22; k++) step();
    checks++;
    if (dout !== 1'b0 || busy !== 1'b1) $display("FAIL pre_abort: dout=%b busy=%b required 0 1", dout, busy);
    else passed++;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({dout, busy, frame_done, sif.s_ready} !== 4'b1000)
      $display("FAIL async_abort: dout/busy/done/rdy=%b required 1000", {dout, busy, frame_done, sif.s_ready});
    else passed++;
    step();
    step();
    resetn = 1'b1;
    #1;
    checks++;
    if (sif.s_ready !== 1'b0) $display("FAIL abort_release_rdy: s_ready=%b required 0", sif.s_ready);
    else passed++;
    step();
    checks++;
    if (sif.s_ready !== 1'b1 || busy !== 1'b0) $display("FAIL abort_recover: s_ready=%b busy=%b required 1 0", sif.s_ready, busy);
    else passed++;
    for (int i = 0; i < 60; i++) begin
      if (frame_done !== 1'b0) pulses++;
      step();
    end
    checks++;
    if (pulses != 0) $display("FAIL abort_no_done: %0d frame_done pulses, required 0", pulses);
    else passed++;
    div = '0;
  endtask

  initial begin
    sif.s_valid = 1'b0;
    sif.s_data = '0;
    #1;
    test_reset();
    test_idle();
    test_frame(8'hA5, 16'd3, 0);
    test_frame(8'h3C, 16'd1, 0);
    test_frame(8'h01, 16'd0, 0);
    test_back_to_back();
    test_frame(8'h5A, 16'd3, 13);
    test_reset_mid_frame();
    test_frame(8'h96, 16'd2, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
